atm_controller_fsm: RTL and testbench
=====================================

Name: atm_controller_fsm

Overview:
- Moore-style control FSM for a teaching ATM (automatic teller machine).
- Sequence: power-on, then 3-digit PIN login entered over a shared 4-bit bus with per-digit strobes, then withdraw (push1) and balance inquiry (push2) against an internal 3-bit cash counter.
- Drives the status LEDs and displays of the top-level board wrapper.

Parameters:
- PIN0, 4'd2, required value of first digit (qualified by checks[0])
- PIN1, 4'd6, required value of second digit (checks[1])
- PIN2, 4'd9, required value of third digit (checks[2])
- SALDO_INIT, 3'd6, cash units loaded at reset (0..7)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- on  in  1  power switch, level
- push1  in  1  withdraw request, level (sampled per clock)
- push2  in  1  balance-inquiry request, level
- password  in  4  current digit value
- checks  in  3  digit-entered strobes; bit i set means digit i is present on password
- Login  out  1  user authenticated
- Encendido  out  1  machine powered (state != OFF)
- pulso  out  1  one-cycle withdrawal pulse
- Display_Saldo  out  1  one-cycle inquiry display strobe
- Vacio  out  1  cash counter is zero
- Display_Login  out  3  per-digit match flags captured during login
- Saldo  out  3  current cash counter

Behaviour:
- Reset (reset=0, async) sets: state=OFF, Saldo=SALDO_INIT, Display_Login=0, checks_q=0, all 1-bit outputs 0 except Vacio=(SALDO_INIT==0).
- All outputs are registered and decoded from state/registers; no input-to-output combinational path.
- States: OFF, LOGIN, IDLE, RETIRO, CONSULTA.
- Power: on=0 at any edge forces OFF next cycle. Clears Display_Login and checks_q. Saldo is retained.
- OFF -> LOGIN when on=1. Encendido=1 in every state except OFF.
- LOGIN, digit capture: for each bit i with checks[i]=1 and checks_q[i]=0 (rising), set Display_Login[i] = (password==PINi). checks_q <= checks every cycle in LOGIN.
- LOGIN, evaluation: on the edge where checks==3'b111 and checks_q[2]==0, evaluate the verdict Display_Login[0] & Display_Login[1] & (password==PIN2), including the digit being captured.
  - Verdict pass: go to IDLE, Login=1.
  - Verdict fail: stay in LOGIN, clear Display_Login and checks_q to 0, so a directly following checks=3'b001 counts as a fresh first digit.
- IDLE:
  - Login=1; checks and password are ignored.
  - push1=1 goes to RETIRO; else push2=1 goes to CONSULTA. push1 has priority when both are high.
- RETIRO (1 cycle):
  - If Saldo>0: pulso=1 and Saldo decrements by 1 on entry.
  - If Saldo==0: pulso=0 and Saldo stays 0 (no wrap).
  - Returns to IDLE next cycle.
- CONSULTA (1 cycle): Display_Saldo=1, then returns to IDLE.
- Push inputs are level-sensitive: a push held high re-triggers after the return to IDLE, i.e. one transaction per 2 cycles.
- Vacio = (Saldo==0), registered, valid in all states.
- Saldo output is always the counter value. Login stays 1 in IDLE, RETIRO and CONSULTA; it is 0 in OFF and LOGIN.

Optional Feature:
- Macro ATM_LOCKOUT_EN.
- When defined: a 2-bit fail counter increments on each failed verdict. The third failure enters state LOCKED, where Encendido=1, Login=0 and all inputs except on are ignored. Only on=0 (to OFF) or reset clears LOCKED and the counter.
- When undefined: failed attempts are unlimited and there is no LOCKED state.

Decomposition:
- Shared package atm_pkg holds the state enum typedef (OFF, LOGIN, IDLE, RETIRO, CONSULTA, LOCKED) and default PIN/SALDO_INIT localparams.
- One natural sub-module: atm_pin_checker, which does digit capture, rising-strobe detection and the verdict. It outputs Display_Login, verdict_valid and verdict_pass.

Test Plan:
- Power gating: on=0 with push1/push2 pulses -> Encendido=0, Login=0, pulso=0, Saldo=6. Then on=1 -> Encendido=1 next edge; pushes while in LOGIN have no effect.
- Wrong PIN: digits 4, 2, 5 with checks 001, 011, 111 -> Display_Login=000, Login stays 0. Partial PIN 2, 6, 5 -> Display_Login shows 011 before the verdict, then is cleared to 000, Login=0.
- Correct PIN: digits 2, 6, 9 -> Login=1 on the edge that samples checks=111. A further checks=111 cycle is ignored.
- Withdraw and inquiry: push1 for 1 cycle -> pulso=1 for 1 cycle, Saldo 6->5. push2 -> Display_Saldo=1 for 1 cycle, Saldo unchanged. Simultaneous push1 and push2 -> withdrawal only.
- Empty: 6 withdrawals total from reset -> Saldo=0, Vacio=1. A 7th push1 -> pulso=0, Saldo stays 0. push2 -> Display_Saldo=1.
- Reset mid-session: reset=0 while in IDLE -> immediate OFF, Saldo=6, Login=0. With ATM_LOCKOUT_EN defined, 3 wrong PINs -> LOCKED, and a correct PIN is then ignored until on is toggled.

Source files
------------

// File: rtl/atm_pkg.sv
// Shared types and default constants for the teaching ATM controller.
package atm_pkg;

  // Controller states. ST_LOCKED is only reachable when ATM_LOCKOUT_EN is defined.
  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_LOGIN    = 3'd1,
    ST_IDLE     = 3'd2,
    ST_RETIRO   = 3'd3,
    ST_CONSULTA = 3'd4,
    ST_LOCKED   = 3'd5
  } atm_state_e;

  // Default PIN digits and cash loaded at reset.
  localparam logic [3:0] PIN0_DEF       = 4'd2;
  localparam logic [3:0] PIN1_DEF       = 4'd6;
  localparam logic [3:0] PIN2_DEF       = 4'd9;
  localparam logic [2:0] SALDO_INIT_DEF = 3'd6;

endpackage : atm_pkg

// File: rtl/atm_pin_checker.sv
// PIN checker: captures one match flag per digit on the rising edge of its
// strobe and produces a verdict when the last strobe of the set rises.
// A failed verdict wipes the captured flags and strobe history so the next
// strobe is treated as a fresh first digit.
module atm_pin_checker
  import atm_pkg::*;
#(
  parameter logic [3:0] PIN0 = PIN0_DEF,
  parameter logic [3:0] PIN1 = PIN1_DEF,
  parameter logic [3:0] PIN2 = PIN2_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear_i,
  input  logic       en_i,
  input  logic [3:0] password_i,
  input  logic [2:0] checks_i,
  output logic [2:0] display_login_o,
  output logic       verdict_valid_o,
  output logic       verdict_pass_o
);

  logic [2:0] checks_q, checks_d;
  logic [2:0] display_login_q, display_login_d;
  logic [2:0] pin_hit;
  logic [2:0] rise;
  logic [2:0] captured;

  // Per-digit match, strobe rising detection and the flags as they would be after this edge.
  always_comb begin
    pin_hit         = {password_i == PIN2, password_i == PIN1, password_i == PIN0};
    rise            = checks_i & ~checks_q;
    captured        = (display_login_q & ~rise) | (pin_hit & rise);
    verdict_valid_o = en_i && (checks_i == 3'b111) && !checks_q[2];
    verdict_pass_o  = verdict_valid_o && captured[0] && captured[1] && pin_hit[2];
  end

  // Next-state for the captured flags and the strobe history.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    checks_d        = checks_q;
    display_login_d = display_login_q;
    if (clear_i) begin
      checks_d        = '0;
      display_login_d = '0;
    end else if (en_i) begin
      if (verdict_valid_o && !verdict_pass_o) begin
        checks_d        = '0;
        display_login_d = '0;
      end else begin
        checks_d        = checks_i;
        display_login_d = captured;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      checks_q        <= '0;
      display_login_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      checks_q        <= checks_d;
      display_login_q <= display_login_d;
    end
  end

  assign display_login_o = display_login_q;

endmodule : atm_pin_checker

// File: rtl/atm_controller_fsm.sv
// Moore control FSM for the teaching ATM: power gating, 3-digit PIN login,
// withdraw (push1, priority) and balance inquiry (push2) against a 3-bit
// cash counter. All outputs come from registers.
// Optional: define ATM_LOCKOUT_EN to lock the machine after three failed
// PIN verdicts until power is cycled or reset is applied.
module atm_controller_fsm
  import atm_pkg::*;
#(
  parameter logic [3:0] PIN0       = PIN0_DEF,
  parameter logic [3:0] PIN1       = PIN1_DEF,
  parameter logic [3:0] PIN2       = PIN2_DEF,
  parameter logic [2:0] SALDO_INIT = SALDO_INIT_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       on,
  input  logic       push1,
  input  logic       push2,
  input  logic [3:0] password,
  input  logic [2:0] checks,
  output logic       Login,
  output logic       Encendido,
  output logic       pulso,
  output logic       Display_Saldo,
  output logic       Vacio,
  output logic [2:0] Display_Login,
  output logic [2:0] Saldo
);

  atm_state_e state_q, state_d;
  logic [2:0] saldo_q, saldo_d;
  logic       pulso_q, pulso_d;
  logic       verdict_valid;
  logic       verdict_pass;
  logic       chk_clear;
  logic       chk_en;

  // The checker only listens while logging in and is wiped whenever power drops.
  assign chk_clear = !on || (state_q == ST_OFF);
  assign chk_en    = on && (state_q == ST_LOGIN);

  atm_pin_checker #(
    .PIN0 (PIN0),
    .PIN1 (PIN1),
    .PIN2 (PIN2)
  ) u_pin_checker (
    .clock           (clock),
    .reset           (reset),
    .clear_i         (chk_clear),
    .en_i            (chk_en),
    .password_i      (password),
    .checks_i        (checks),
    .display_login_o (Display_Login),
    .verdict_valid_o (verdict_valid),
    .verdict_pass_o  (verdict_pass)
  );

`ifdef ATM_LOCKOUT_EN
  logic [1:0] fail_cnt_q, fail_cnt_d;

  // Failed-verdict counter, cleared only by power-off or reset.
  always_comb begin
    fail_cnt_d = fail_cnt_q;
    if (!on) begin
      fail_cnt_d = '0;
    end else if ((state_q == ST_LOGIN) && verdict_valid && !verdict_pass) begin
      fail_cnt_d = fail_cnt_q + 2'd1;
    end
  end

  // Fail counter register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fail_cnt_q <= '0;
    end else begin
      fail_cnt_q <= fail_cnt_d;
    end
  end
`endif

  // Next state, cash counter update and withdrawal pulse.
  always_comb begin
    state_d = state_q;
    saldo_d = saldo_q;
    pulso_d = 1'b0;
    if (!on) begin
      state_d = ST_OFF;
    end else begin
      case (state_q)
        ST_OFF:   state_d = ST_LOGIN;
        ST_LOGIN: begin
          if (verdict_valid) begin
            if (verdict_pass) begin
              state_d = ST_IDLE;
            end else begin
`ifdef ATM_LOCKOUT_EN
              if (fail_cnt_q == 2'd2) begin
                state_d = ST_LOCKED;
              end
`endif
            end
          end
        end
        ST_IDLE: begin
          if (push1) begin
            state_d = ST_RETIRO;
            // An empty machine enters the withdraw cycle but pays nothing out.
            if (saldo_q != 3'd0) begin
              saldo_d = saldo_q - 3'd1;
              pulso_d = 1'b1;
            end
          end else if (push2) begin
            state_d = ST_CONSULTA;
          end
        end
        ST_RETIRO:   state_d = ST_IDLE;
        ST_CONSULTA: state_d = ST_IDLE;
`ifdef ATM_LOCKOUT_EN
        ST_LOCKED:   state_d = ST_LOCKED;
`endif
        default:     state_d = ST_OFF;
      endcase
    end
  end

  // Controller registers; cash survives power-off and is reloaded only by reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_OFF;
      saldo_q <= SALDO_INIT;
      pulso_q <= 1'b0;
    end else begin
      state_q <= state_d;
      saldo_q <= saldo_d;
      pulso_q <= pulso_d;
    end
  end

  assign Encendido     = (state_q != ST_OFF);
  assign Login         = (state_q == ST_IDLE) || (state_q == ST_RETIRO) || (state_q == ST_CONSULTA);
  assign Display_Saldo = (state_q == ST_CONSULTA);
  assign pulso         = pulso_q;
  assign Vacio         = (saldo_q == 3'd0);
  assign Saldo         = saldo_q;

endmodule : atm_controller_fsm

// File: tb/tb_atm_controller_fsm.sv
// Self-checking bench for atm_controller_fsm: a behavioural model is
// compared against every output on every falling edge, and directed steps
// pin the model with literal expectations. Honors ATM_LOCKOUT_EN.
module tb_atm_controller_fsm;

`ifdef ATM_LOCKOUT_EN
  localparam bit LOCKOUT = 1'b1;
  localparam int EXP_LOGIN_WHILE_LOCKED = 0;
`else
  localparam bit LOCKOUT = 1'b0;
  localparam int EXP_LOGIN_WHILE_LOCKED = 1;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       on    = 1'b0;
  logic       push1 = 1'b0;
  logic       push2 = 1'b0;
  logic [3:0] password = 4'd0;
  logic [2:0] checks   = 3'd0;
  logic       Login, Encendido, pulso, Display_Saldo, Vacio;
  logic [2:0] Display_Login, Saldo;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  atm_controller_fsm dut (
    .clock         (clock),
    .reset         (reset),
    .on            (on),
    .push1         (push1),
    .push2         (push2),
    .password      (password),
    .checks        (checks),
    .Login         (Login),
    .Encendido     (Encendido),
    .pulso         (pulso),
    .Display_Saldo (Display_Saldo),
    .Vacio         (Vacio),
    .Display_Login (Display_Login),
    .Saldo         (Saldo)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit       m_pow, m_auth, m_lock, m_busy, m_pulse, m_disp;
  int       m_cash, m_fails;
  bit [2:0] m_flags, m_prev;
  bit       cmp_en = 1'b0;

  task automatic model_reset();
    m_pow = 0; m_auth = 0; m_lock = 0; m_busy = 0; m_pulse = 0; m_disp = 0;
    m_cash = 6; m_fails = 0; m_flags = '0; m_prev = '0;
  endtask

  function automatic bit [3:0] pin_digit(input int i);
    case (i)
      0:       return 4'd2;
      1:       return 4'd6;
      default: return 4'd9;
    endcase
  endfunction

  task automatic model_step();
    bit eval;
    m_pulse = 0;
    m_disp  = 0;
    if (!on) begin
      m_pow = 0; m_auth = 0; m_lock = 0; m_busy = 0;
      m_flags = '0; m_prev = '0; m_fails = 0;
    end else if (!m_pow) begin
      m_pow = 1;
    end else if (m_lock) begin
      m_lock = 1;
    end else if (!m_auth) begin
      eval = (checks == 3'b111) && !m_prev[2];
      for (int i = 0; i < 3; i++)
        if (checks[i] && !m_prev[i]) m_flags[i] = (password == pin_digit(i));
      m_prev = checks;
      if (eval) begin
        if (m_flags == 3'b111) begin
          m_auth = 1;
        end else begin
          m_flags = '0;
          m_prev  = '0;
          m_fails++;
          if (LOCKOUT && m_fails >= 3) m_lock = 1;
        end
      end
    end else if (m_busy) begin
      m_busy = 0;
    end else if (push1) begin
      m_busy = 1;
      if (m_cash > 0) begin
        m_cash--;
        m_pulse = 1;
      end
    end else if (push2) begin
      m_busy = 1;
      m_disp = 1;
    end
  endtask

  always @(negedge reset) model_reset();
  always @(posedge clock) if (reset) model_step();

  // Compare every output against the model away from the active edge.
  always @(negedge clock) begin
    if (cmp_en) begin
      check("cmp_Encendido",     Encendido,     m_pow);
      check("cmp_Login",         Login,         m_pow && m_auth && !m_lock);
      check("cmp_pulso",         pulso,         m_pulse);
      check("cmp_Display_Saldo", Display_Saldo, m_disp);
      check("cmp_Vacio",         Vacio,         m_cash == 0);
      check("cmp_Display_Login", Display_Login, m_flags);
      check("cmp_Saldo",         Saldo,         m_cash);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clock);
    @(negedge clock);
    #1;
  endtask

  task automatic digit(input logic [3:0] d, input logic [2:0] c);
    password = d;
    checks   = c;
    step();
  endtask

  task automatic wrong_pin();
    digit(4'd4, 3'b001);
    digit(4'd2, 3'b011);
    digit(4'd5, 3'b111);
  endtask

  task automatic good_pin();
    digit(4'd2, 3'b001);
    digit(4'd6, 3'b011);
    digit(4'd9, 3'b111);
  endtask

  initial begin
    model_reset();
    #1 reset = 1'b0;
    cmp_en = 1'b1;
    #20;
    check("rst_Saldo", Saldo, 6);
    check("rst_Encendido", Encendido, 0);
    check("rst_Vacio", Vacio, 0);
    check("rst_Display_Login", Display_Login, 0);
    reset = 1'b1;

    // Power gating
    push1 = 1; step();
    check("off_pulso", pulso, 0);
    check("off_Saldo", Saldo, 6);
    push1 = 0; push2 = 1; step();
    check("off_Display_Saldo", Display_Saldo, 0);
    check("off_Encendido", Encendido, 0);
    push2 = 0; on = 1; step();
    check("on_Encendido", Encendido, 1);
    check("on_Login", Login, 0);
    push1 = 1; step();
    check("login_push1_pulso", pulso, 0);
    check("login_push1_Saldo", Saldo, 6);
    push1 = 0; push2 = 1; step();
    check("login_push2_Display_Saldo", Display_Saldo, 0);
    push2 = 0;

    // Wrong PIN 4,2,5
    digit(4'd4, 3'b001); check("wp_d0", Display_Login, 3'b000);
    digit(4'd2, 3'b011); check("wp_d1", Display_Login, 3'b000);
    digit(4'd5, 3'b111); check("wp_d2", Display_Login, 3'b000);
    check("wp_Login", Login, 0);
    // Partial PIN 2,6,5
    digit(4'd2, 3'b001); check("pp_d0", Display_Login, 3'b001);
    digit(4'd6, 3'b011); check("pp_d1", Display_Login, 3'b011);
    digit(4'd5, 3'b111); check("pp_d2", Display_Login, 3'b000);
    check("pp_Login", Login, 0);
    // Correct PIN straight after the failure: 001 is a fresh first digit
    digit(4'd2, 3'b001); check("ok_d0", Display_Login, 3'b001);
    digit(4'd6, 3'b011);
    digit(4'd9, 3'b111);
    check("ok_Login", Login, 1);
    check("ok_Display_Login", Display_Login, 3'b111);
    digit(4'd9, 3'b111);
    check("ok_repeat_Login", Login, 1);
    check("ok_repeat_pulso", pulso, 0);
    checks = 3'b000;

    // Withdraw and inquiry
    push1 = 1; step();
    check("wd_pulso", pulso, 1);
    check("wd_Saldo", Saldo, 5);
    push1 = 0; step();
    check("wd_pulso_end", pulso, 0);
    push2 = 1; step();
    check("inq_Display_Saldo", Display_Saldo, 1);
    check("inq_Saldo", Saldo, 5);
    push2 = 0; step();
    check("inq_end", Display_Saldo, 0);
    push1 = 1; push2 = 1; step();
    check("both_pulso", pulso, 1);
    check("both_Display_Saldo", Display_Saldo, 0);
    check("both_Saldo", Saldo, 4);
    push2 = 0;
    step();
    // push1 held: one transaction per 2 cycles
    step(); check("held1_Saldo", Saldo, 3);
    step(); check("held2_pulso", pulso, 0);
    step(); check("held3_Saldo", Saldo, 2);
    step();
    step(); check("held5_Saldo", Saldo, 1);
    push1 = 0; step();
    push1 = 1; step();
    check("empty_Saldo", Saldo, 0);
    check("empty_Vacio", Vacio, 1);
    check("empty_pulso", pulso, 1);
    push1 = 0; step();
    push1 = 1; step();
    check("seventh_pulso", pulso, 0);
    check("seventh_Saldo", Saldo, 0);
    push1 = 0; step();
    push2 = 1; step();
    check("empty_inq", Display_Saldo, 1);
    push2 = 0; step();

    // Reset mid-session (asynchronous)
    reset = 1'b0;
    #1;
    check("mid_rst_Saldo", Saldo, 6);
    check("mid_rst_Login", Login, 0);
    check("mid_rst_Encendido", Encendido, 0);
    @(negedge clock); #1;
    reset = 1'b1;
    step();
    check("relogin_Encendido", Encendido, 1);

    // Three wrong PINs then a correct one
    wrong_pin(); wrong_pin(); wrong_pin();
    check("lock_Login", Login, 0);
    check("lock_Encendido", Encendido, 1);
    good_pin();
    check("lock_good_Login", Login, EXP_LOGIN_WHILE_LOCKED);
    checks = 3'b000;
    on = 0; step();
    check("cycle_off_Encendido", Encendido, 0);
    check("cycle_off_Display_Login", Display_Login, 0);
    on = 1; step();
    good_pin();
    check("cycle_good_Login", Login, 1);
    checks = 3'b000;
    step();

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_atm_controller_fsm
